// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

    localparam int unsigned A_LENGTH   = 12;
    localparam int unsigned D_LENGTH   = 8;
    localparam int unsigned WORD_W     = 4 * D_LENGTH;
    localparam int unsigned LEN_W      = A_LENGTH - 1;
    localparam int unsigned LANE_W     = 2;
    localparam logic [31:0] IMEM_BASE  = 32'hBFC00000;
    localparam int unsigned IMEM_BYTES = 4096;
    localparam int unsigned IMEM_WORDS = 1024;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } loader_state_t;

endpackage

// File: rtl/imem_loader_packer.sv
// word_packer: gathers four stream bytes into one little-endian word, lane 0 first.
module word_packer
    import imem_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                clr,
    input  logic [D_LENGTH-1:0] byte_in,
    output logic [WORD_W-1:0]   word_out,
    output logic                full
);

    logic [LANE_W-1:0] lane_q;

    // clr empties every lane so a completed word can be merged with the last byte by OR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q   <= '0;
            word_out <= '0;
        end else if (clr) begin
            lane_q   <= '0;
            word_out <= '0;
        end else if (load) begin
            word_out[32'(lane_q) * D_LENGTH +: D_LENGTH] <= byte_in;
            lane_q                                       <= lane_q + LANE_W'(1);
        end
    end

    assign full = (lane_q == LANE_W'(3));

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into 32-bit words and writes them sequentially into instruction RAM from address 0.
module imem_loader
    import imem_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LEN_W-1:0]    len_words,
    input  logic                in_valid,
    input  logic [D_LENGTH-1:0] in_byte,
    output logic                in_ready,
    output logic                wr_en,
    output logic [A_LENGTH-1:0] wr_addr,
    output logic [WORD_W-1:0]   wr_data,
    output logic                busy,
    output logic                done,
    output logic                err
);

    loader_state_t       state_q, state_d;
    logic                in_ready_d, busy_d, wr_en_d, done_d;
    logic [LEN_W-1:0]    len_q, word_cnt_q;
    logic [A_LENGTH-1:0] addr_q;
    logic [WORD_W-1:0]   word_out;
    logic                lane_full;
    logic                accept_c, len_ok_c, last_word_c, start_c, word_done_c, pack_clr_c;

    assign accept_c    = in_valid && in_ready;
    assign start_c     = (state_q == IDLE) && start;
    assign len_ok_c    = (len_words <= LEN_W'(IMEM_WORDS));
    assign last_word_c = ((word_cnt_q + LEN_W'(1)) == len_q);
    assign word_done_c = accept_c && lane_full;
    assign pack_clr_c  = start_c || (state_q == WRITE);

    word_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept_c),
        .clr      (pack_clr_c),
        .byte_in  (in_byte),
        .word_out (word_out),
        .full     (lane_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            wr_en    <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_ready <= in_ready_d;
            busy     <= busy_d;
            wr_en    <= wr_en_d;
            done     <= done_d;
        end
    end

    // Next state, with the status outputs decoded from the state being entered
    always_comb begin
        state_d    = state_q;
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
        wr_en_d    = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_words == '0) state_d = DONE;
                    else if (len_ok_c)   state_d = COLLECT;
                end
            end
            COLLECT: if (word_done_c) state_d = WRITE;
            WRITE:   state_d = last_word_c ? DONE : COLLECT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        case (state_d)
            COLLECT: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
            WRITE: begin
                wr_en_d = 1'b1;
                busy_d  = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    // Length/address bookkeeping; the write port is only reloaded when a word completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            err        <= 1'b0;
        end else begin
            if (start_c) begin
                if (len_ok_c) begin
                    err        <= 1'b0;
                    len_q      <= len_words;
                    word_cnt_q <= '0;
                    addr_q     <= '0;
                end else begin
                    err <= 1'b1;
                end
            end
            if (word_done_c) begin
                wr_addr <= addr_q;
                wr_data <= word_out | {in_byte, {(WORD_W - D_LENGTH){1'b0}}};
            end
            if (state_q == WRITE) begin
                addr_q     <= addr_q + A_LENGTH'(4);
                word_cnt_q <= word_cnt_q + LEN_W'(1);
            end
        end
    end

endmodule
